// File: rtl/loop_controller_if.sv
// Bracket-op, redirect and scan-stream signals for the loop controller.
// No logic; a bundle only.
// The master side presents ops and scan opcodes; the slave side answers with acks and redirects.
interface loop_controller_if #(
  parameter int IA_WIDTH = 12,
  parameter int ID_WIDTH = 8,
  parameter int SP_WIDTH = 4
);
  logic                br_valid;
  logic                br_close;
  logic [IA_WIDTH-1:0] br_pc;
  logic                br_zero;
  logic                br_ack;
  logic                pc_load;
  logic [IA_WIDTH-1:0] pc_d;
  logic                flush;
  logic                sc_valid;
  logic [ID_WIDTH-1:0] sc_opcode;
  logic                sc_ack;
  logic                scanning;
  logic [SP_WIDTH:0]   depth;
  logic                halted;
  logic                err_overflow;
  logic                err_underflow;

  modport master (
    output br_valid, br_close, br_pc, br_zero, sc_valid, sc_opcode,
    input  br_ack, pc_load, pc_d, flush, sc_ack, scanning, depth,
           halted, err_overflow, err_underflow
  );

  modport slave (
    input  br_valid, br_close, br_pc, br_zero, sc_valid, sc_opcode,
    output br_ack, pc_load, pc_d, flush, sc_ack, scanning, depth,
           halted, err_overflow, err_underflow
  );
endinterface

// File: rtl/loop_controller.sv
// Loop head stack and bracket sequencer: push on '[', redirect on taken ']', scan over skipped loops.
// br_ack/pc_load/flush are registered, one cycle after br_valid is sampled; sc_ack is combinational.
// An op is held by the requester until br_ack; an asserted br_ack blocks re-accepting the same op.
module loop_controller #(
  parameter int IA_WIDTH    = 12,
  parameter int ID_WIDTH    = 8,
  parameter int STACK_DEPTH = 16,
  parameter int SP_WIDTH    = 4,
  parameter int NEST_WIDTH  = 8
) (
  input logic              clk,
  input logic              reset,
  loop_controller_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_HALT} state_t;

  localparam logic [SP_WIDTH:0]     SP_FULL   = (SP_WIDTH+1)'(STACK_DEPTH);
  localparam logic [SP_WIDTH:0]     SP_ONE    = (SP_WIDTH+1)'(1);
  localparam logic [NEST_WIDTH-1:0] NEST_ONE  = NEST_WIDTH'(1);
  localparam logic [ID_WIDTH-1:0]   OP_OPEN   = ID_WIDTH'(8'h5B);
  localparam logic [ID_WIDTH-1:0]   OP_CLOSE  = ID_WIDTH'(8'h5D);

  state_t                state_q, state_d;
  logic [SP_WIDTH:0]     sp_q, sp_d;
  logic [NEST_WIDTH-1:0] nest_q, nest_d;
  logic                  ack_q, ack_d;
  logic                  load_q, load_d;
  logic                  flush_q, flush_d;
  logic [IA_WIDTH-1:0]   pcd_q, pcd_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  push;
  logic [SP_WIDTH-1:0]   rd_idx;
  logic [IA_WIDTH-1:0]   stack [STACK_DEPTH];

  // Top-of-stack index; wraps to the last slot when the stack is full.
  assign rd_idx = sp_q[SP_WIDTH-1:0] - SP_WIDTH'(1);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and datapath decisions for bracket ops and scan opcodes.
  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    nest_d  = nest_q;
    ack_d   = 1'b0;
    load_d  = 1'b0;
    flush_d = 1'b0;
    pcd_d   = pcd_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.br_valid && !ack_q) begin
          if (!bus.br_close) begin
            if (bus.br_zero) begin
              ack_d   = 1'b1;
              flush_d = 1'b1;
              nest_d  = NEST_ONE;
              state_d = S_SCAN;
            end else if (sp_q == SP_FULL) begin
              ovf_d   = 1'b1;
              state_d = S_HALT;
            end else begin
              push  = 1'b1;
              sp_d  = sp_q + SP_ONE;
              ack_d = 1'b1;
            end
          end else if (sp_q == '0) begin
            unf_d   = 1'b1;
            state_d = S_HALT;
          end else if (bus.br_zero) begin
            sp_d  = sp_q - SP_ONE;
            ack_d = 1'b1;
          end else begin
            // Loop taken: resume just after the '[', head stays stacked.
            pcd_d   = stack[rd_idx] + IA_WIDTH'(1);
            load_d  = 1'b1;
            flush_d = 1'b1;
            ack_d   = 1'b1;
          end
        end
      end
      S_SCAN: begin
        if (bus.sc_valid) begin
          if (bus.sc_opcode == OP_OPEN) begin
            if (&nest_q) begin
              ovf_d   = 1'b1;
              state_d = S_HALT;
            end else begin
              nest_d = nest_q + NEST_ONE;
            end
          end else if (bus.sc_opcode == OP_CLOSE) begin
            nest_d = nest_q - NEST_ONE;
            if (nest_q == NEST_ONE) state_d = S_IDLE;
          end
        end
      end
      S_HALT:  ;
      default: state_d = S_IDLE;
    endcase
  end

  // Stack pointer, nesting counter, strobes and sticky error flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp_q    <= '0;
      nest_q  <= '0;
      ack_q   <= 1'b0;
      load_q  <= 1'b0;
      flush_q <= 1'b0;
      pcd_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      nest_q  <= nest_d;
      ack_q   <= ack_d;
      load_q  <= load_d;
      flush_q <= flush_d;
      pcd_q   <= pcd_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Loop head storage; contents are meaningless above sp, so no reset.
  always_ff @(posedge clk) begin
    if (push) stack[sp_q[SP_WIDTH-1:0]] <= bus.br_pc;
  end

  // Outputs derived from state and registered strobes.
  always_comb begin
    bus.br_ack        = ack_q;
    bus.pc_load       = load_q;
    bus.pc_d          = pcd_q;
    bus.flush         = flush_q;
    bus.scanning      = (state_q == S_SCAN);
    bus.sc_ack        = (state_q == S_SCAN);
    bus.halted        = (state_q == S_HALT);
    bus.depth         = sp_q;
    bus.err_overflow  = ovf_q;
    bus.err_underflow = unf_q;
  end

endmodule

// File: tb/tb_loop_controller.sv
module tb_loop_controller;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  loop_controller_if #(.IA_WIDTH(12), .ID_WIDTH(8), .SP_WIDTH(4)) bus ();

  loop_controller #(
    .IA_WIDTH(12), .ID_WIDTH(8), .STACK_DEPTH(16), .SP_WIDTH(4), .NEST_WIDTH(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        ack;
    logic        load;
    logic        flush;
    logic        scan;
    logic        halt;
    logic        ovf;
    logic        unf;
    logic [4:0]  depth;
    logic [11:0] pcd;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  int          m_sp;
  int          m_nest;
  logic [11:0] m_stack [16];
  logic        m_scan, m_halt, m_ovf, m_unf;

  function automatic logic [11:0] observe();
    return {bus.br_ack, bus.pc_load, bus.flush, bus.scanning, bus.halted,
            bus.err_overflow, bus.err_underflow, bus.depth};
  endfunction

  function automatic logic [11:0] expv(exp_t e);
    return {e.ack, e.load, e.flush, e.scan, e.halt, e.ovf, e.unf, e.depth};
  endfunction

  task automatic model_clear();
    m_sp = 0; m_nest = 0; m_scan = 0; m_halt = 0; m_ovf = 0; m_unf = 0;
    exp_q.delete();
  endtask

  task automatic model_status(inout exp_t e);
    e.scan = m_scan; e.halt = m_halt; e.ovf = m_ovf; e.unf = m_unf;
    e.depth = 5'(m_sp);
  endtask

  task automatic model_op(input logic close, input logic [11:0] pc, input logic zero,
                          output exp_t e);
    e = '0;
    if (!m_halt && !m_scan) begin
      if (!close) begin
        if (zero) begin
          e.ack = 1; e.flush = 1; m_scan = 1; m_nest = 1;
        end else if (m_sp == 16) begin
          m_ovf = 1; m_halt = 1;
        end else begin
          m_stack[m_sp] = pc; m_sp++; e.ack = 1;
        end
      end else if (m_sp == 0) begin
        m_unf = 1; m_halt = 1;
      end else if (zero) begin
        m_sp--; e.ack = 1;
      end else begin
        e.load = 1; e.flush = 1; e.ack = 1;
        e.pcd = m_stack[m_sp-1] + 12'd1;
      end
    end
    model_status(e);
  endtask

  task automatic model_scan(input logic [7:0] op, output exp_t e);
    e = '0;
    if (m_scan && !m_halt) begin
      if (op == 8'h5B) begin
        if (m_nest == 255) begin
          m_ovf = 1; m_halt = 1; m_scan = 0;
        end else m_nest++;
      end else if (op == 8'h5D) begin
        m_nest--;
        if (m_nest == 0) m_scan = 0;
      end
    end
    model_status(e);
  endtask

  // Present one bracket op, compare the pulse cycle, then the cycle after it.
  task automatic issue_op(input logic close, input logic [11:0] pc, input logic zero,
                          input string name);
    exp_t e, got;
    logic [11:0] obs;
    model_op(close, pc, zero, e);
    exp_q.push_back(e);
    @(negedge clk);
    bus.br_valid = 1'b1; bus.br_close = close; bus.br_pc = pc; bus.br_zero = zero;
    @(posedge clk); #1;
    got = exp_q.pop_front();
    obs = observe();
    checks++;
    if (obs !== expv(got)) begin
      failures++;
      $display("FAIL %s: ack/load/flush/scan/halt/ovf/unf/depth got %b want %b",
               name, obs, expv(got));
    end
    if (got.load) begin
      checks++;
      if (bus.pc_d !== got.pcd) begin
        failures++;
        $display("FAIL %s pc_d: got %h want %h", name, bus.pc_d, got.pcd);
      end
    end
    @(negedge clk);
    bus.br_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({bus.br_ack, bus.pc_load, bus.flush} !== 3'b000) begin
      failures++;
      $display("FAIL %s pulse width: ack/load/flush got %b want 000", name,
               {bus.br_ack, bus.pc_load, bus.flush});
    end
  endtask

  // Feed one scan opcode, optionally with a bracket op held on br_valid.
  task automatic scan_op(input logic [7:0] op, input logic hold_br, input string name);
    exp_t e, got;
    logic [11:0] obs;
    model_status(e);
    @(negedge clk);
    bus.sc_valid = 1'b1; bus.sc_opcode = op;
    bus.br_valid = hold_br; bus.br_close = 1'b0; bus.br_zero = 1'b0; bus.br_pc = 12'h0AA;
    #1;
    checks++;
    if (bus.sc_ack !== m_scan) begin
      failures++;
      $display("FAIL %s sc_ack: got %b want %b", name, bus.sc_ack, m_scan);
    end
    model_scan(op, e);
    exp_q.push_back(e);
    @(posedge clk); #1;
    got = exp_q.pop_front();
    obs = observe();
    checks++;
    if (obs !== expv(got)) begin
      failures++;
      $display("FAIL %s: ack/load/flush/scan/halt/ovf/unf/depth got %b want %b",
               name, obs, expv(got));
    end
    @(negedge clk);
    bus.sc_valid = 1'b0; bus.br_valid = 1'b0;
  endtask

  // Assert reset mid-cycle, check everything cleared before the next edge, release.
  task automatic do_reset(input string name);
    @(negedge clk);
    reset = 1'b0;
    #2;
    checks++;
    if ({bus.br_ack, bus.pc_load, bus.flush, bus.sc_ack, bus.scanning, bus.halted,
         bus.err_overflow, bus.err_underflow, bus.depth, bus.pc_d} !== '0) begin
      failures++;
      $display("FAIL %s: outputs not cleared, obs=%b sc_ack=%b pc_d=%h", name,
               observe(), bus.sc_ack, bus.pc_d);
    end
    model_clear();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset("reset");
  endtask

  task automatic test_push_exit();
    issue_op(1'b0, 12'h010, 1'b0, "push_open");
    issue_op(1'b1, 12'h020, 1'b1, "exit_close");
  endtask

  task automatic test_loop_back();
    issue_op(1'b0, 12'h010, 1'b0, "loop_open");
    for (int i = 0; i < 3; i++) issue_op(1'b1, 12'h030, 1'b0, "loop_back");
    checks++;
    if (bus.pc_d !== 12'h011) begin
      failures++;
      $display("FAIL loop_target: pc_d got %h want 011", bus.pc_d);
    end
    issue_op(1'b1, 12'h030, 1'b1, "loop_exit");
  endtask

  task automatic test_skip_scan();
    logic [7:0] ops [5];
    ops = '{8'h2B, 8'h5B, 8'h3E, 8'h5D, 8'h5D};
    issue_op(1'b0, 12'h005, 1'b1, "skip_open");
    for (int i = 0; i < 5; i++) scan_op(ops[i], (i < 3), "skip_scan");
  endtask

  task automatic test_back_to_back();
    exp_t e, got;
    logic [11:0] obs;
    @(negedge clk);
    bus.br_valid = 1'b1; bus.br_close = 1'b0; bus.br_zero = 1'b0; bus.br_pc = 12'h100;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) model_op(1'b0, 12'h100, 1'b0, e);
      else begin e = '0; model_status(e); end
      exp_q.push_back(e);
      @(posedge clk); #1;
      got = exp_q.pop_front();
      obs = observe();
      checks++;
      if (obs !== expv(got)) begin
        failures++;
        $display("FAIL back_to_back[%0d]: got %b want %b", i, obs, expv(got));
      end
    end
    @(negedge clk);
    bus.br_valid = 1'b0;
    issue_op(1'b1, 12'h200, 1'b1, "b2b_pop");
    issue_op(1'b1, 12'h200, 1'b1, "b2b_pop");
  endtask

  task automatic test_overflow();
    do_reset("reset_ovf");
    for (int i = 0; i < 17; i++) issue_op(1'b0, 12'(12'h040 + i), 1'b0, "ovf_push");
    issue_op(1'b1, 12'h050, 1'b0, "halt_ignore_br");
    scan_op(8'h5D, 1'b1, "halt_ignore_sc");
  endtask

  task automatic test_underflow();
    do_reset("reset_unf");
    issue_op(1'b1, 12'h060, 1'b0, "underflow");
  endtask

  task automatic test_nest_overflow();
    do_reset("reset_nest");
    issue_op(1'b0, 12'h070, 1'b1, "nest_open");
    for (int i = 0; i < 254; i++) scan_op(8'h5B, 1'b0, "nest_fill");
    scan_op(8'h5B, 1'b0, "nest_overflow");
  endtask

  task automatic test_reset_mid_scan();
    do_reset("reset_pre");
    issue_op(1'b0, 12'h080, 1'b0, "mid_push");
    issue_op(1'b0, 12'h081, 1'b1, "mid_skip");
    scan_op(8'h5B, 1'b0, "mid_nest2");
    do_reset("reset_mid_scan");
    issue_op(1'b0, 12'h090, 1'b0, "post_reset_push");
  endtask

  initial begin
    reset = 1'b0;
    bus.br_valid = 1'b0; bus.br_close = 1'b0; bus.br_pc = '0; bus.br_zero = 1'b0;
    bus.sc_valid = 1'b0; bus.sc_opcode = '0;
    model_clear();
    test_reset();
    test_push_exit();
    test_loop_back();
    test_skip_scan();
    test_back_to_back();
    test_overflow();
    test_underflow();
    test_nest_overflow();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
